// File: rtl/tcp_tx_pattern_gen_if.sv
// tcp_tx_pattern_gen_if: SiTCP TX write port plus RBCP run control/status for the pattern generator.
interface tcp_tx_pattern_gen_if;
  logic        TCP_OPEN_ACK;
  logic        TCP_TX_FULL;
  logic        START;
  logic        STOP;
  logic [15:0] FRAME_LEN;
  logic [31:0] FRAME_NUM;
  logic        TCP_TX_WR;
  logic [7:0]  TCP_TX_DATA;
  logic        BUSY;
  logic        DONE;
  logic        ABORT;
  logic [31:0] FRAME_CNT;
  modport master (
    input  TCP_OPEN_ACK, TCP_TX_FULL, START, STOP, FRAME_LEN, FRAME_NUM,
    output TCP_TX_WR, TCP_TX_DATA, BUSY, DONE, ABORT, FRAME_CNT
  );
  modport slave (
    output TCP_OPEN_ACK, TCP_TX_FULL, START, STOP, FRAME_LEN, FRAME_NUM,
    input  TCP_TX_WR, TCP_TX_DATA, BUSY, DONE, ABORT, FRAME_CNT
  );
endinterface

// File: rtl/tcp_tx_pattern_gen.sv
// tcp_tx_pattern_gen: framed test-pattern source for the SiTCP TCP TX port.
// Frame = sync(2) + seq(2) + FRAME_LEN counting bytes, with back-pressure, stop and abort handling.
module tcp_tx_pattern_gen #(
  parameter int          GAP_CYCLES = 16,
  parameter logic [15:0] HDR_SYNC   = 16'hA55A
) (
  input logic                  CLK,
  input logic                  RSTn,
  tcp_tx_pattern_gen_if.master bus
);
  typedef enum logic [1:0] {IDLE, HDR, PAY, GAP} state_t;
  state_t      st_q, st_d;
  logic [15:0] idx_q, idx_d, gap_q, gap_d, len_q, len_d;
  logic [31:0] num_q, num_d, cnt_q, cnt_d;
  logic        wr_q, wr_d, busy_q, busy_d, done_q, done_d, abort_q, abort_d, stop_q, stop_d;
  logic [7:0]  data_q, data_d, hdr_byte;
  logic        issue, last, fin;
  assign issue    = (st_q == HDR || st_q == PAY) && !bus.TCP_TX_FULL;
  assign last     = st_q == PAY ? idx_q == len_q - 16'd1 : (idx_q == 16'd3 && len_q == 16'd0);
  assign fin      = (num_q != 32'd0 && cnt_q + 32'd1 == num_q) || stop_q || bus.STOP;
  assign hdr_byte = idx_q[1] ? (idx_q[0] ? cnt_q[7:0] : cnt_q[15:8])
                             : (idx_q[0] ? HDR_SYNC[7:0] : HDR_SYNC[15:8]);
  always_comb begin
    st_d    = st_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    len_d   = len_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    stop_d  = stop_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    if (st_q == IDLE) begin
      if (bus.START && bus.TCP_OPEN_ACK) begin
        st_d    = HDR;
        idx_d   = '0;
        len_d   = bus.FRAME_LEN;
        num_d   = bus.FRAME_NUM;
        cnt_d   = '0;
        abort_d = 1'b0;
        stop_d  = 1'b0;
      end
    end else if (!bus.TCP_OPEN_ACK) begin
      // Connection loss wins over everything, but a frame finishing this cycle is still counted.
      st_d    = IDLE;
      abort_d = 1'b1;
      cnt_d   = issue && last ? cnt_q + 32'd1 : cnt_q;
    end else if (st_q == GAP) begin
      if (bus.STOP) begin
        st_d   = IDLE;
        done_d = 1'b1;
      end else if (gap_q == 16'(GAP_CYCLES - 1)) begin
        st_d  = HDR;
        idx_d = '0;
      end else
        gap_d = gap_q + 16'd1;
    end else begin
      stop_d = stop_q | bus.STOP;
      if (issue) begin
        wr_d   = 1'b1;
        data_d = st_q == HDR ? hdr_byte : idx_q[7:0];
        idx_d  = idx_q + 16'd1;
        if (last) begin
          cnt_d = cnt_q + 32'd1;
          idx_d = '0;
          if (fin) begin
            st_d   = IDLE;
            done_d = 1'b1;
          end else if (GAP_CYCLES == 0)
            st_d = HDR;
          else begin
            st_d  = GAP;
            gap_d = '0;
          end
        end else if (st_q == HDR && idx_q == 16'd3) begin
          st_d  = PAY;
          idx_d = '0;
        end
      end
    end
    busy_d = st_d != IDLE;
  end
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      st_q    <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      len_q   <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      len_q   <= len_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      stop_q  <= stop_d;
    end
  assign bus.TCP_TX_WR   = wr_q;
  assign bus.TCP_TX_DATA = data_q;
  assign bus.BUSY        = busy_q;
  assign bus.DONE        = done_q;
  assign bus.ABORT       = abort_q;
  assign bus.FRAME_CNT   = cnt_q;
endmodule
